vx_csr_access_unit: RTL and testbench

Issue side of the core's CSR data interface. Accepts decoded CSR instructions (CSRRW/CSRRS/CSRRC, register or immediate source) from the dispatch stage and reads the addressed CSR. It computes the read-modify-write value and issues the write to the CSR data block one cycle later. It then returns the old CSR value to writeback, replicated across active threads, on a valid/ready response port.

---
 rtl/vx_csr_access_unit.sv | 149 ++++++++++++++
 tb/tb_vx_csr_access_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_csr_access_unit.sv
// CSR access unit: reads the addressed CSR on accept, issues the read-modify-write
// one cycle later, and returns the old value to writeback on a valid/ready port.
module vx_csr_access_unit #(
    parameter int NUM_THREADS   = 4,
    parameter int NW_BITS       = 2,
    parameter int UUID_BITS     = 44,
    parameter int CSR_ADDR_BITS = 12,
    parameter int NR_BITS       = 5
) (
    input  logic                      clk,
    input  logic                      reset,

    // Handshakes: a transfer happens on a cycle where valid & ready are both high;
    // the producer holds valid and payload stable until that cycle.
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [UUID_BITS-1:0]      req_uuid,
    input  logic [NW_BITS-1:0]        req_wid,
    input  logic [NUM_THREADS-1:0]    req_tmask,
    input  logic [1:0]                req_op,
    input  logic [CSR_ADDR_BITS-1:0]  req_addr,
    input  logic                      req_use_imm,
    input  logic [4:0]                req_imm,
    input  logic [31:0]               req_rs1_data,
    input  logic [NR_BITS-1:0]        req_rd,
    input  logic                      req_wb,

    output logic                      csr_read_enable,
    output logic [UUID_BITS-1:0]      csr_read_uuid,
    output logic [CSR_ADDR_BITS-1:0]  csr_read_addr,
    output logic [NW_BITS-1:0]        csr_read_wid,
    input  logic [31:0]               csr_read_data,

    output logic                      csr_write_enable,
    output logic [UUID_BITS-1:0]      csr_write_uuid,
    output logic [CSR_ADDR_BITS-1:0]  csr_write_addr,
    output logic [NW_BITS-1:0]        csr_write_wid,
    output logic [31:0]               csr_write_data,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [UUID_BITS-1:0]      rsp_uuid,
    output logic [NW_BITS-1:0]        rsp_wid,
    output logic [NUM_THREADS-1:0]    rsp_tmask,
    output logic [NR_BITS-1:0]        rsp_rd,
    output logic                      rsp_wb,
    output logic [NUM_THREADS*32-1:0] rsp_data
);

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    logic                     rsp_valid_q;
    logic                     wr_pending;
    logic [UUID_BITS-1:0]     uuid_q;
    logic [NW_BITS-1:0]       wid_q;
    logic [NUM_THREADS-1:0]   tmask_q;
    logic [CSR_ADDR_BITS-1:0] addr_q;
    logic [NR_BITS-1:0]       rd_q;
    logic                     wb_q;
    logic [31:0]              old_q;
    logic [31:0]              new_q;

    logic        fire;
    logic [31:0] src;
    logic [31:0] new_value;
    logic        write_dec;

    // A pending write stalls the next accept so any following read sees it landed.
    assign req_ready = ~reset & ~wr_pending & (~rsp_valid_q | rsp_ready);
    assign fire      = req_valid & req_ready;

    assign csr_read_enable = fire;
    assign csr_read_uuid   = req_uuid;
    assign csr_read_addr   = req_addr;
    assign csr_read_wid    = req_wid;

    assign src = req_use_imm ? {27'b0, req_imm} : req_rs1_data;

    // Illegal op 00 behaves as a set that never writes.
    always_comb begin
        new_value = csr_read_data | src;
        write_dec = 1'b0;
        case (req_op)
            OP_RW: begin
                new_value = src;
                write_dec = 1'b1;
            end
            OP_RS: write_dec = (src != 32'b0);
            OP_RC: begin
                new_value = csr_read_data & ~src;
                write_dec = (src != 32'b0);
            end
            default: write_dec = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            wr_pending  <= 1'b0;
        end else if (fire) begin
            rsp_valid_q <= 1'b1;
            wr_pending  <= write_dec;
        end else begin
            wr_pending <= 1'b0;
            if (rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            uuid_q  <= req_uuid;
            wid_q   <= req_wid;
            tmask_q <= req_tmask;
            addr_q  <= req_addr;
            rd_q    <= req_rd;
            wb_q    <= req_wb;
            old_q   <= csr_read_data;
            new_q   <= new_value;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && fire) begin
            assert (req_op != 2'b00)
            else $error("vx_csr_access_unit: illegal CSR op 00 accepted");
        end
    end

    // Strobes are masked during reset so a write caught mid-flight is dropped.
    assign csr_write_enable = wr_pending & ~reset;
    assign csr_write_uuid   = uuid_q;
    assign csr_write_addr   = addr_q;
    assign csr_write_wid    = wid_q;
    assign csr_write_data   = new_q;

    assign rsp_valid = rsp_valid_q & ~reset;
    assign rsp_uuid  = uuid_q;
    assign rsp_wid   = wid_q;
    assign rsp_tmask = tmask_q;
    assign rsp_rd    = rd_q;
    assign rsp_wb    = wb_q;
    assign rsp_data  = {NUM_THREADS{old_q}};

endmodule

// File: tb/tb_vx_csr_access_unit.sv
// Bench for vx_csr_access_unit: table of single-instruction vectors plus
// hand sequences for hazards, back-to-back reads, backpressure and reset.
module tb_vx_csr_access_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [43:0]  req_uuid;
  logic [1:0]   req_wid;
  logic [3:0]   req_tmask;
  logic [1:0]   req_op;
  logic [11:0]  req_addr;
  logic         req_use_imm;
  logic [4:0]   req_imm;
  logic [31:0]  req_rs1_data;
  logic [4:0]   req_rd;
  logic         req_wb;
  logic         csr_read_enable;
  logic [43:0]  csr_read_uuid;
  logic [11:0]  csr_read_addr;
  logic [1:0]   csr_read_wid;
  logic [31:0]  csr_read_data;
  logic         csr_write_enable;
  logic [43:0]  csr_write_uuid;
  logic [11:0]  csr_write_addr;
  logic [1:0]   csr_write_wid;
  logic [31:0]  csr_write_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [43:0]  rsp_uuid;
  logic [1:0]   rsp_wid;
  logic [3:0]   rsp_tmask;
  logic [4:0]   rsp_rd;
  logic         rsp_wb;
  logic [127:0] rsp_data;

  vx_csr_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_uuid(req_uuid), .req_wid(req_wid),
    .req_tmask(req_tmask), .req_op(req_op), .req_addr(req_addr), .req_use_imm(req_use_imm),
    .req_imm(req_imm), .req_rs1_data(req_rs1_data), .req_rd(req_rd), .req_wb(req_wb),
    .csr_read_enable(csr_read_enable), .csr_read_uuid(csr_read_uuid),
    .csr_read_addr(csr_read_addr), .csr_read_wid(csr_read_wid), .csr_read_data(csr_read_data),
    .csr_write_enable(csr_write_enable), .csr_write_uuid(csr_write_uuid),
    .csr_write_addr(csr_write_addr), .csr_write_wid(csr_write_wid),
    .csr_write_data(csr_write_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_uuid(rsp_uuid), .rsp_wid(rsp_wid),
    .rsp_tmask(rsp_tmask), .rsp_rd(rsp_rd), .rsp_wb(rsp_wb), .rsp_data(rsp_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  // CSR data block model; FFLAGS/FRM/FCSR alias one 8-bit register
  logic [31:0] csr_mem [0:4095];
  logic [7:0]  fcsr;
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;
  logic [11:0] wa;
  logic [31:0] wd;
  int          wr_count = 0;

  always_comb begin
    case (csr_read_addr)
      12'h001: csr_read_data = {27'b0, fcsr[4:0]};
      12'h002: csr_read_data = {29'b0, fcsr[7:5]};
      12'h003: csr_read_data = {24'b0, fcsr};
      default: csr_read_data = csr_mem[csr_read_addr];
    endcase
  end

  assign wa = pre_en ? pre_addr : csr_write_addr;
  assign wd = pre_en ? pre_data : csr_write_data;

  always @(posedge clk) begin
    if (csr_write_enable) wr_count <= wr_count + 1;
    if (pre_en || csr_write_enable) begin
      case (wa)
        12'h001: fcsr[4:0] <= wd[4:0];
        12'h002: fcsr[7:5] <= wd[2:0];
        12'h003: fcsr      <= wd[7:0];
        default: csr_mem[wa] <= wd;
      endcase
    end
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [75:0] exp_q[$];
  logic [43:0] uuid_ctr = 44'h0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic preload(input logic [11:0] addr, input logic [31:0] data);
    pre_en = 1'b1; pre_addr = addr; pre_data = data;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic drive(input logic [1:0] op, input logic ui, input logic [4:0] imm,
                       input logic [31:0] rs1, input logic [11:0] addr, input logic [3:0] tmask);
    uuid_ctr     = uuid_ctr + 44'h1_0000_0001;
    req_uuid     = uuid_ctr;
    req_wid      = uuid_ctr[1:0];
    req_rd       = uuid_ctr[4:0];
    req_wb       = 1'b1;
    req_op       = op;
    req_use_imm  = ui;
    req_imm      = imm;
    req_rs1_data = rs1;
    req_addr     = addr;
    req_tmask    = tmask;
    req_valid    = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic        use_imm;
    logic [4:0]  imm;
    logic [31:0] rs1;
    logic [11:0] addr;
    logic [31:0] init;
    logic [3:0]  tmask;
    logic        exp_we;
    logic [31:0] exp_new;
  } vec_t;

  vec_t vecs[8];
  logic [43:0] u1, u2, ub;
  logic [1:0]  wb_wid;
  logic [4:0]  wb_rd;
  int          base_wr;
  logic [31:0] ro_vals[4];
  logic [11:0] ro_addrs[4];
  logic [75:0] e;

  initial begin
    //                op     imm  immv   rs1           addr    init          tmask    we    final
    vecs[0] = '{2'b10, 1'b0, 5'h00, 32'h3,        12'h300, 32'h8,        4'b1011, 1'b1, 32'hB};
    vecs[1] = '{2'b11, 1'b1, 5'h00, 32'hFFFF,     12'h301, 32'hFF,       4'b1111, 1'b0, 32'hFF};
    vecs[2] = '{2'b01, 1'b0, 5'h00, 32'hDEADBEEF, 12'h340, 32'h12345678, 4'b0001, 1'b1, 32'hDEADBEEF};
    vecs[3] = '{2'b11, 1'b0, 5'h00, 32'h0F,       12'h341, 32'hFF,       4'b0110, 1'b1, 32'hF0};
    vecs[4] = '{2'b10, 1'b1, 5'h1F, 32'h0,        12'h342, 32'h100,      4'b1000, 1'b1, 32'h11F};
    vecs[5] = '{2'b01, 1'b1, 5'h00, 32'hFFFF,     12'h343, 32'hAAAA,     4'b1111, 1'b1, 32'h0};
    vecs[6] = '{2'b10, 1'b0, 5'h00, 32'h0,        12'h344, 32'h5,        4'b0011, 1'b0, 32'h5};
    vecs[7] = '{2'b11, 1'b1, 5'h10, 32'h0,        12'h345, 32'hFFFFFFFF, 4'b1100, 1'b1, 32'hFFFFFFEF};
    ro_addrs = '{12'hCC0, 12'hCC1, 12'hCC2, 12'hF14};
    ro_vals  = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h0};

    reset = 1'b1; rsp_ready = 1'b1;
    drive(2'b10, 1'b0, 5'h0, 32'h0, 12'h300, 4'hF);
    @(negedge clk);
    @(negedge clk);
    check("reset_req_ready", req_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_write_en", csr_write_enable, 0);
    check("reset_read_en", csr_read_enable, 0);
    req_valid = 1'b0;
    reset = 1'b0;
    #1 check("ready_after_reset", req_ready, 1);

    for (int i = 0; i < 8; i++) preload(vecs[i].addr, vecs[i].init);
    preload(12'h003, 32'h0);
    for (int i = 0; i < 4; i++) preload(ro_addrs[i], ro_vals[i]);
    preload(12'h350, 32'h11);
    preload(12'h360, 32'h0);

    // table-driven single instructions, rsp_ready high
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].op, vecs[i].use_imm, vecs[i].imm, vecs[i].rs1, vecs[i].addr, vecs[i].tmask);
      u1 = req_uuid; wb_wid = req_wid; wb_rd = req_rd;
      #1;
      check($sformatf("v%0d_req_ready", i), req_ready, 1);
      check($sformatf("v%0d_read_en", i), csr_read_enable, 1);
      @(negedge clk);
      req_valid = 1'b0;
      check($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
      check($sformatf("v%0d_rsp_data", i), rsp_data, {4{vecs[i].init}});
      check($sformatf("v%0d_rsp_tags", i), {rsp_uuid, rsp_wid, rsp_tmask, rsp_rd, rsp_wb},
            {u1, wb_wid, vecs[i].tmask, wb_rd, 1'b1});
      check($sformatf("v%0d_write_en", i), csr_write_enable, vecs[i].exp_we);
      if (vecs[i].exp_we)
        check($sformatf("v%0d_write", i), {csr_write_addr, csr_write_uuid, csr_write_data},
              {vecs[i].addr, u1, vecs[i].exp_new});
      check($sformatf("v%0d_bubble", i), req_ready, !vecs[i].exp_we);
      @(negedge clk);
      check($sformatf("v%0d_rsp_done", i), rsp_valid, 0);
      check($sformatf("v%0d_write_once", i), csr_write_enable, 0);
      check($sformatf("v%0d_model", i), csr_mem[vecs[i].addr], vecs[i].exp_new);
    end

    // FRM write then FCSR read back-to-back: second accepted one cycle late
    drive(2'b01, 1'b1, 5'h05, 32'h0, 12'h002, 4'hF);
    u1 = req_uuid;
    @(negedge clk);
    drive(2'b10, 1'b0, 5'h00, 32'h0, 12'h003, 4'hF);
    u2 = req_uuid;
    check("haz_rsp1", {rsp_valid, rsp_uuid, rsp_data[31:0]}, {1'b1, u1, 32'h0});
    check("haz_write", {csr_write_enable, csr_write_addr, csr_write_data}, {1'b1, 12'h002, 32'h5});
    check("haz_stall", req_ready, 0);
    @(negedge clk);
    check("haz_accept_n2", {req_ready, csr_read_enable, csr_read_addr}, {1'b1, 1'b1, 12'h003});
    check("haz_rsp1_gone", rsp_valid, 0);
    @(negedge clk);
    req_valid = 1'b0;
    check("haz_rsp2", {rsp_valid, rsp_uuid, rsp_data}, {1'b1, u2, {4{32'h0000_00A0}}});
    check("haz_no_write2", csr_write_enable, 0);
    @(negedge clk);

    // back-to-back read-only CSRs, one response per cycle in order
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        e = exp_q.pop_front();
        check($sformatf("b2b_rsp%0d", i - 1), {rsp_valid, rsp_uuid, rsp_data[31:0]}, {1'b1, e});
        check($sformatf("b2b_nowrite%0d", i - 1), csr_write_enable, 0);
      end
      if (i < 4) begin
        drive(2'b10, 1'b0, 5'h0, 32'h0, ro_addrs[i], 4'hF);
        exp_q.push_back({req_uuid, ro_vals[i]});
        #1 check($sformatf("b2b_ready%0d", i), req_ready, 1);
        @(negedge clk);
      end else begin
        req_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_drained", rsp_valid, 0);

    // backpressure: write strobes once, response held stable
    rsp_ready = 1'b0;
    base_wr = wr_count;
    drive(2'b01, 1'b0, 5'h0, 32'h77, 12'h350, 4'b0101);
    u1 = req_uuid;
    #1 check("bp_ready0", req_ready, 1);
    @(negedge clk);
    drive(2'b10, 1'b0, 5'h0, 32'h0, 12'h350, 4'hF);
    ub = req_uuid;
    check("bp_write", {csr_write_enable, csr_write_data}, {1'b1, 32'h77});
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) rsp_ready = 1'b1;
      #1;
      check($sformatf("bp_rsp_c%0d", c), {rsp_valid, rsp_uuid, rsp_tmask, rsp_data},
            {1'b1, u1, 4'b0101, {4{32'h11}}});
      if (c > 1) check($sformatf("bp_we_c%0d", c), csr_write_enable, 0);
      check($sformatf("bp_ready_c%0d", c), req_ready, c == 4);
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("bp_write_count", wr_count - base_wr, 1);
    check("bp_rsp2", {rsp_valid, rsp_uuid, rsp_data[31:0]}, {1'b1, ub, 32'h77});
    @(negedge clk);
    check("bp_drained", rsp_valid, 0);

    // reset while a write is pending and the response is stalled
    rsp_ready = 1'b0;
    drive(2'b10, 1'b0, 5'h0, 32'h1, 12'h360, 4'hF);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_we_before", csr_write_enable, 1);
    reset = 1'b1;
    #1;
    check("rst_we_during", csr_write_enable, 0);
    check("rst_rsp_during", rsp_valid, 0);
    check("rst_ready_during", req_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_rsp_after", rsp_valid, 0);
    check("rst_we_after", csr_write_enable, 0);
    check("rst_ready_after", req_ready, 1);
    @(negedge clk);
    check("rst_no_stale", rsp_valid, 0);
    rsp_ready = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
